sprite_renderer: RTL and testbench

Parametrised object draw engine for the 160x120 game display. On each frame tick it snapshots the positions of NUM_OBJ rectangular objects. It then erases every object's previous rectangle in the background colour and draws every new rectangle. Pixels stream one per cycle to the VGA adapter's x/y/colour/plot inputs. It also reports bounding-box collisions between object 0 (player) and every other object, replacing the fixed single-pixel player/obstacle datapath.

---
 rtl/game_pkg.sv | 33 +++
 rtl/sprite_renderer_if.sv | 36 +++
 rtl/rect_scanner.sv | 64 ++++++
 rtl/sprite_renderer.sv | 240 ++++++++++++++++++++++++
 tb/tb_sprite_renderer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game display datapath.
//   SCREEN_W/SCREEN_H  visible area of the 160x120 framebuffer
//   BLACK/RED/BLUE     3-bit colour constants
//   OBJ_*_DEFAULT      default object rectangle size
//   render_state_e     sprite_renderer pass state encoding
//   aabb_overlap()     strict rectangle overlap test (edge-adjacent does not overlap)
package game_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] BLUE  = 3'b001;

  localparam int unsigned OBJ_W_DEFAULT = 8;
  localparam int unsigned OBJ_H_DEFAULT = 8;

  typedef enum logic [1:0] {
    StIdle,
    StErase,
    StDraw,
    StFinish
  } render_state_e;

  // Operands are zero-extended to 16 bits by the caller so the sums never wrap.
  function automatic logic aabb_overlap(input logic [15:0] ax, input logic [15:0] ay,
                                        input logic [15:0] bx, input logic [15:0] by,
                                        input logic [15:0] w,  input logic [15:0] h);
    return (ax < bx + w) && (bx < ax + w) && (ay < by + h) && (by < ay + h);
  endfunction

endpackage

// File: rtl/sprite_renderer_if.sv
// Object/pixel bus between the game logic and the sprite renderer.
//   frame_tick, obj_x, obj_y, obj_colour, obj_en  : object snapshot request (master -> slave)
//   x, y, colour, plot                            : pixel stream to the VGA adapter
//   busy, done, hit, overrun                      : pass status and collision result
interface sprite_renderer_if #(
  parameter int unsigned NUM_OBJ  = 2,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOUR_W = 3
);

  logic                          frame_tick;
  logic [NUM_OBJ*X_W-1:0]        obj_x;
  logic [NUM_OBJ*Y_W-1:0]        obj_y;
  logic [NUM_OBJ*COLOUR_W-1:0]   obj_colour;
  logic [NUM_OBJ-1:0]            obj_en;
  logic [X_W-1:0]                x;
  logic [Y_W-1:0]                y;
  logic [COLOUR_W-1:0]           colour;
  logic                          plot;
  logic                          busy;
  logic                          done;
  logic [NUM_OBJ-1:0]            hit;
  logic                          overrun;

  modport master (
    output frame_tick, obj_x, obj_y, obj_colour, obj_en,
    input  x, y, colour, plot, busy, done, hit, overrun
  );

  modport slave (
    input  frame_tick, obj_x, obj_y, obj_colour, obj_en,
    output x, y, colour, plot, busy, done, hit, overrun
  );

endinterface

// File: rtl/rect_scanner.sv
// Row-major walk over one OBJ_W x OBJ_H rectangle, one pixel per cycle.
//   start          : (re)start the walk at (0,0); may be asserted on the last pixel
//   base_x/base_y  : rectangle origin, held by the caller for the whole walk
//   px/py          : current pixel, one bit wider than the origin so it never wraps
//   valid          : a pixel is being scanned this cycle
//   last           : this is the final pixel of the rectangle
module rect_scanner #(
  parameter int unsigned OBJ_W = 8,
  parameter int unsigned OBJ_H = 8,
  parameter int unsigned X_W   = 8,
  parameter int unsigned Y_W   = 7
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [X_W-1:0] base_x,
  input  logic [Y_W-1:0] base_y,
  output logic [X_W:0]   px,
  output logic [Y_W:0]   py,
  output logic           valid,
  output logic           last
);

  localparam int unsigned COL_W = (OBJ_W > 1) ? $clog2(OBJ_W) : 1;
  localparam int unsigned ROW_W = (OBJ_H > 1) ? $clog2(OBJ_H) : 1;

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             active_q;
  logic             col_end;
  logic             row_end;

  assign col_end = (col_q == COL_W'(OBJ_W - 1));
  assign row_end = (row_q == ROW_W'(OBJ_H - 1));
  assign valid   = active_q;
  assign last    = active_q & col_end & row_end;
  assign px      = {1'b0, base_x} + (X_W + 1)'(col_q);
  assign py      = {1'b0, base_y} + (Y_W + 1)'(row_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      col_q    <= '0;
      row_q    <= '0;
    end else if (active_q) begin
      if (col_end) begin
        col_q <= '0;
        if (row_end) begin
          row_q    <= '0;
          active_q <= 1'b0;
        end else begin
          row_q <= row_q + ROW_W'(1);
        end
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_renderer.sv
// Object draw engine: on frame_tick, erase every previously drawn object in BG_COLOUR,
// then draw every enabled object, streaming one pixel per cycle; reports player (object 0)
// bounding-box collisions at the end of each pass.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : object snapshot inputs, pixel stream and status outputs
module sprite_renderer import game_pkg::*; #(
  parameter int unsigned          NUM_OBJ   = 2,
  parameter int unsigned          OBJ_W     = OBJ_W_DEFAULT,
  parameter int unsigned          OBJ_H     = OBJ_H_DEFAULT,
  parameter int unsigned          X_W       = 8,
  parameter int unsigned          Y_W       = 7,
  parameter int unsigned          COLOUR_W  = 3,
  parameter int unsigned          SCREEN_W  = game_pkg::SCREEN_W,
  parameter int unsigned          SCREEN_H  = game_pkg::SCREEN_H,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR = COLOUR_W'(BLACK)
) (
  input logic              clock,
  input logic              reset,
  sprite_renderer_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  render_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             scan_start;

  logic [NUM_OBJ*X_W-1:0]      new_x_q, old_x_q;
  logic [NUM_OBJ*Y_W-1:0]      new_y_q, old_y_q;
  logic [NUM_OBJ*COLOUR_W-1:0] new_colour_q;
  logic [NUM_OBJ-1:0]          new_en_q, old_valid_q;

  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d, busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
  logic [NUM_OBJ-1:0]  hit_q, hit_d, hit_now;

  logic [X_W-1:0] base_x;
  logic [Y_W-1:0] base_y;
  logic [X_W:0]   scan_px;
  logic [Y_W:0]   scan_py;
  logic           scan_valid, scan_last;

  // Next object to scan in each phase: lowest enabled index, and lowest one above idx_q.
  logic [NUM_OBJ-1:0] draw_mask;
  logic [IDX_W-1:0]   er_first, er_next, dr_first, dr_next;
  logic               er_first_ok, er_next_ok, dr_first_ok, dr_next_ok;

  always_comb begin
    // In IDLE the snapshot is not latched yet, so look at the live enables.
    draw_mask   = (state_q == StIdle) ? bus.obj_en : new_en_q;
    er_first    = '0;
    er_next     = '0;
    dr_first    = '0;
    dr_next     = '0;
    er_first_ok = 1'b0;
    er_next_ok  = 1'b0;
    dr_first_ok = 1'b0;
    dr_next_ok  = 1'b0;
    for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
      if (old_valid_q[i]) begin
        er_first_ok = 1'b1;
        er_first    = IDX_W'(i);
        if (IDX_W'(i) > idx_q) begin
          er_next_ok = 1'b1;
          er_next    = IDX_W'(i);
        end
      end
      if (draw_mask[i]) begin
        dr_first_ok = 1'b1;
        dr_first    = IDX_W'(i);
        if (IDX_W'(i) > idx_q) begin
          dr_next_ok = 1'b1;
          dr_next    = IDX_W'(i);
        end
      end
    end
  end

  // Next-state logic. Objects that are not enabled are skipped without spending a cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    scan_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.frame_tick) begin
          scan_start = er_first_ok | dr_first_ok;
          if (er_first_ok) begin
            state_d = StErase;
            idx_d   = er_first;
          end else if (dr_first_ok) begin
            state_d = StDraw;
            idx_d   = dr_first;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StErase: begin
        if (scan_last) begin
          scan_start = er_next_ok | dr_first_ok;
          if (er_next_ok) begin
            idx_d = er_next;
          end else if (dr_first_ok) begin
            state_d = StDraw;
            idx_d   = dr_first;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StDraw: begin
        if (scan_last) begin
          scan_start = dr_next_ok;
          if (dr_next_ok) begin
            idx_d = dr_next;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign base_x = (state_q == StErase) ? old_x_q[idx_q*X_W +: X_W] : new_x_q[idx_q*X_W +: X_W];
  assign base_y = (state_q == StErase) ? old_y_q[idx_q*Y_W +: Y_W] : new_y_q[idx_q*Y_W +: Y_W];

  rect_scanner #(
    .OBJ_W (OBJ_W),
    .OBJ_H (OBJ_H),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_scanner (
    .clock  (clock),
    .reset  (reset),
    .start  (scan_start),
    .base_x (base_x),
    .base_y (base_y),
    .px     (scan_px),
    .py     (scan_py),
    .valid  (scan_valid),
    .last   (scan_last)
  );

  always_comb begin
    hit_now = '0;
    for (int i = 1; i < int'(NUM_OBJ); i++) begin
      hit_now[i] = new_en_q[0] & new_en_q[i] &
                   aabb_overlap(16'(new_x_q[0 +: X_W]), 16'(new_y_q[0 +: Y_W]),
                                16'(new_x_q[i*X_W +: X_W]), 16'(new_y_q[i*Y_W +: Y_W]),
                                16'(OBJ_W), 16'(OBJ_H));
    end
  end

  // Output logic: next values of the registered pixel and status outputs.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    hit_d     = hit_q;
    busy_d    = (state_d != StIdle);
    done_d    = (state_q == StFinish);
    overrun_d = bus.frame_tick && (state_q != StIdle);
    if ((state_q == StErase || state_q == StDraw) && scan_valid) begin
      x_d      = scan_px[X_W-1:0];
      y_d      = scan_py[Y_W-1:0];
      colour_d = (state_q == StErase) ? BG_COLOUR : new_colour_q[idx_q*COLOUR_W +: COLOUR_W];
      // Off-screen pixels still take their cycle but are not written.
      plot_d   = (scan_px < (X_W + 1)'(SCREEN_W)) && (scan_py < (Y_W + 1)'(SCREEN_H));
    end
    if (state_q == StFinish) begin
      hit_d = hit_now;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      new_x_q      <= '0;
      new_y_q      <= '0;
      new_colour_q <= '0;
      new_en_q     <= '0;
      old_x_q      <= '0;
      old_y_q      <= '0;
      old_valid_q  <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hit_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      if (state_q == StIdle && bus.frame_tick) begin
        new_x_q      <= bus.obj_x;
        new_y_q      <= bus.obj_y;
        new_colour_q <= bus.obj_colour;
        new_en_q     <= bus.obj_en;
      end
      if (state_q == StFinish) begin
        old_x_q     <= new_x_q;
        old_y_q     <= new_y_q;
        old_valid_q <= new_en_q;
      end
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hit_q     <= hit_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.colour  = colour_q;
  assign bus.plot    = plot_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hit     = hit_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: a table of object snapshots is applied pass by pass; a
// reference model of the erase/draw scan pushes expected visible pixels to a queue that
// is popped as plot pulses arrive. Pass length, plot count, hit and overrun are checked
// against hand-derived constants in the table.
module tb_sprite_renderer;
  import game_pkg::*;

  localparam int unsigned NUM_OBJ  = 2;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  sprite_renderer_if #(
    .NUM_OBJ  (NUM_OBJ),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .COLOUR_W (COLOUR_W)
  ) bus ();

  sprite_renderer #(
    .NUM_OBJ   (NUM_OBJ),
    .OBJ_W     (8),
    .OBJ_H     (8),
    .X_W       (X_W),
    .Y_W       (Y_W),
    .COLOUR_W  (COLOUR_W),
    .SCREEN_W  (160),
    .SCREEN_H  (120),
    .BG_COLOUR (3'b000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    int x0, y0, c0, en0;
    int x1, y1, c1, en1;
    int exp_hit, exp_plots, exp_len;
  } vec_t;

  pix_t exp_q[$];
  vec_t vecs[8];
  int   n_pass  = 0;
  int   n_total = 0;
  int   m_old_x[2];
  int   m_old_y[2];
  bit   m_old_valid[2];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_rect(input int bx, input int by, input int c);
    pix_t p;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        if (bx + k < 160 && by + r < 120) begin
          p.x = 8'(bx + k);
          p.y = 7'(by + r);
          p.c = 3'(c);
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic set_inputs(input vec_t v);
    bus.obj_x      = {8'(v.x1), 8'(v.x0)};
    bus.obj_y      = {7'(v.y1), 7'(v.y0)};
    bus.obj_colour = {3'(v.c1), 3'(v.c0)};
    bus.obj_en     = {1'(v.en1), 1'(v.en0)};
  endtask

  // One full pass; ovr_at >= 0 pulses frame_tick that many cycles into the pass.
  task automatic run_pass(input vec_t v, input int ovr_at, input string tag);
    int   n, plots, ovr;
    bit   seen_done;
    pix_t act, p;
    int   nx[2], ny[2], nc[2], ne[2];
    nx = '{v.x0, v.x1};
    ny = '{v.y0, v.y1};
    nc = '{v.c0, v.c1};
    ne = '{v.en0, v.en1};
    exp_q.delete();
    for (int i = 0; i < 2; i++) if (m_old_valid[i]) push_rect(m_old_x[i], m_old_y[i], 0);
    for (int i = 0; i < 2; i++) if (ne[i] != 0) push_rect(nx[i], ny[i], nc[i]);
    for (int i = 0; i < 2; i++) begin
      m_old_x[i]     = nx[i];
      m_old_y[i]     = ny[i];
      m_old_valid[i] = (ne[i] != 0);
    end

    @(negedge clock);
    set_inputs(v);
    bus.frame_tick = 1'b1;
    @(posedge clock);
    #1;
    bus.frame_tick = 1'b0;
    check({tag, " busy_start"}, int'(bus.busy), 1);
    n = 0; plots = 0; ovr = 0; seen_done = 1'b0;
    while (!seen_done && n < 2000) begin
      if (n == ovr_at) bus.frame_tick = 1'b1;
      @(posedge clock);
      #1;
      bus.frame_tick = 1'b0;
      n++;
      if (n == 5) begin
        // Inputs moving mid-pass must not disturb it.
        bus.obj_x      = ~bus.obj_x;
        bus.obj_y      = ~bus.obj_y;
        bus.obj_colour = ~bus.obj_colour;
        bus.obj_en     = ~bus.obj_en;
      end
      if (bus.overrun) ovr++;
      if (bus.plot) begin
        plots++;
        act = {bus.x, bus.y, bus.colour};
        if (exp_q.size() == 0) begin
          check({tag, " extra_pixel"}, int'(act), -1);
        end else begin
          p = exp_q.pop_front();
          check({tag, " pixel"}, int'(act), int'(p));
        end
      end
      if (bus.done) begin
        seen_done = 1'b1;
        check({tag, " busy_at_done"}, int'(bus.busy), 0);
      end
    end
    check({tag, " pass_len"}, n, v.exp_len);
    check({tag, " plot_count"}, plots, v.exp_plots);
    check({tag, " hit"}, int'(bus.hit), v.exp_hit);
    check({tag, " overrun_pulses"}, ovr, (ovr_at >= 0) ? 1 : 0);
    check({tag, " pixels_left"}, exp_q.size(), 0);
    @(posedge clock);
    #1;
    check({tag, " done_width"}, int'(bus.done), 0);
  endtask

  initial begin
    vec_t v;
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.obj_x      = '0;
    bus.obj_y      = '0;
    bus.obj_colour = '0;
    bus.obj_en     = '0;
    for (int i = 0; i < 2; i++) begin
      m_old_x[i]     = 0;
      m_old_y[i]     = 0;
      m_old_valid[i] = 1'b0;
    end

    //          x0   y0   c0        en0  x1  y1  c1         en1 hit plots len
    vecs[0] = '{20,  60,  int'(RED), 1,  0,  0,  int'(BLUE), 0,  0,  64,  65};
    vecs[1] = '{20,  58,  int'(RED), 1,  0,  0,  int'(BLUE), 0,  0,  128, 129};
    vecs[2] = '{156, 116, int'(RED), 1,  0,  0,  int'(BLUE), 0,  0,  80,  129};
    vecs[3] = '{20,  60,  int'(RED), 1,  24, 64, int'(BLUE), 1,  2,  144, 193};
    vecs[4] = '{20,  60,  int'(RED), 1,  28, 60, int'(BLUE), 1,  0,  256, 257};
    vecs[5] = '{20,  60,  int'(RED), 0,  28, 60, int'(BLUE), 0,  0,  128, 129};
    vecs[6] = '{20,  60,  int'(RED), 0,  28, 60, int'(BLUE), 0,  0,  0,   1};
    vecs[7] = '{0,   0,   int'(RED), 1,  7,  7,  2,          1,  2,  128, 129};

    repeat (3) @(posedge clock);
    #1;
    check("reset x", int'(bus.x), 0);
    check("reset y", int'(bus.y), 0);
    check("reset colour", int'(bus.colour), 0);
    check("reset plot", int'(bus.plot), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset hit", int'(bus.hit), 0);
    check("reset overrun", int'(bus.overrun), 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_pass(vecs[i], -1, $sformatf("vec%0d", i));

    // Tick mid-pass: flagged, ignored, no follow-on pass.
    v           = vecs[7];
    v.exp_plots = 256;
    v.exp_len   = 257;
    run_pass(v, 10, "overrun");
    repeat (5) @(posedge clock);
    #1;
    check("no_extra_pass busy", int'(bus.busy), 0);

    // Reset in the middle of the draw phase (erase takes cycles 1..128).
    @(negedge clock);
    set_inputs(vecs[7]);
    bus.frame_tick = 1'b1;
    @(posedge clock);
    #1;
    bus.frame_tick = 1'b0;
    repeat (150) @(posedge clock);
    #1;
    check("abort pre busy", int'(bus.busy), 1);
    check("abort pre plot", int'(bus.plot), 1);
    reset = 1'b1;
    #1;
    check("abort plot", int'(bus.plot), 0);
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    check("abort hit", int'(bus.hit), 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) m_old_valid[i] = 1'b0;
    run_pass(vecs[0], -1, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
